// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT pass sequencer: op encodings, per-mode
// pass geometry and FSM states.
package ntt_pkg;

    localparam int unsigned WORDS      = 32;
    localparam int unsigned NTT_STAGES = 7;
    localparam int unsigned NTT_LAT    = 6;
    localparam int unsigned MULT_CPW   = 4;
    localparam int unsigned MULT_LAT   = 12;
    localparam int unsigned ADD_CPW    = 2;
    localparam int unsigned ADD_LAT    = 4;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STAGE_W = 3;

    // Read cycles per pass for each mode
    localparam int unsigned NTT_R  = WORDS;
    localparam int unsigned MULT_R = WORDS * MULT_CPW;
    localparam int unsigned ADD_R  = WORDS * ADD_CPW;

    localparam int unsigned NTT_P  = NTT_STAGES;
    localparam int unsigned MULT_P = 1;
    localparam int unsigned ADD_P  = 1;

    typedef enum logic [1:0] {
        NTT    = 2'd0,
        INVNTT = 2'd1,
        MULT   = 2'd2,
        ADDSUB = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ntt_seq_ctrl_if.sv
// Handshake and address-generator bus between the Kyber controller, the
// pass sequencer and the address generator.
interface ntt_seq_ctrl_if;
    logic       start;
    logic [1:0] op;
    logic [1:0] mode;
    logic [2:0] stage;
    logic [7:0] cycle_cnt;
    logic       rd_en;
    logic       wr_en;
    logic       busy;
    logic       done;

    modport master (
        output start, op,
        input  mode, stage, cycle_cnt, rd_en, wr_en, busy, done
    );

    modport slave (
        input  start, op,
        output mode, stage, cycle_cnt, rd_en, wr_en, busy, done
    );
endinterface

// File: rtl/ntt_pass_limits.sv
// Combinational per-mode pass geometry: read cycles, read-to-write latency and
// index of the final stage.
module ntt_pass_limits
    import ntt_pkg::*;
(
    input  op_e                mode,
    output logic [CNT_W-1:0]   rd_len,
    output logic [CNT_W-1:0]   lat,
    output logic [STAGE_W-1:0] last_stage
);

    always_comb begin
        rd_len     = CNT_W'(NTT_R);
        lat        = CNT_W'(NTT_LAT);
        last_stage = STAGE_W'(NTT_P - 1);
        unique case (mode)
            NTT, INVNTT: begin
                rd_len     = CNT_W'(NTT_R);
                lat        = CNT_W'(NTT_LAT);
                last_stage = STAGE_W'(NTT_P - 1);
            end
            MULT: begin
                rd_len     = CNT_W'(MULT_R);
                lat        = CNT_W'(MULT_LAT);
                last_stage = STAGE_W'(MULT_P - 1);
            end
            ADDSUB: begin
                rd_len     = CNT_W'(ADD_R);
                lat        = CNT_W'(ADD_LAT);
                last_stage = STAGE_W'(ADD_P - 1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Polynomial-unit pass sequencer: walks stage/cycle_cnt through every pass of
// one operation and issues read/write strobes aligned to the datapath latency.
module ntt_seq_ctrl
    import ntt_pkg::*;
(
    input logic            clk,
    input logic            rst,
    ntt_seq_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    op_e                 mode_q, mode_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rd_en_q, wr_en_q, busy_q, done_q;
    logic                rd_en_d, wr_en_d, busy_d, done_d;

    logic [CNT_W-1:0]    rd_len, lat, wr_end;
    logic [STAGE_W-1:0]  last_stage;

    ntt_pass_limits u_limits (
        .mode       (mode_q),
        .rd_len     (rd_len),
        .lat        (lat),
        .last_stage (last_stage)
    );

    // One past the final write cycle of a pass (R+L); at most 140, fits CNT_W
    assign wr_end = rd_len + lat;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                stage_d = '0;
                cnt_d   = '0;
                if (bus.start) begin
                    mode_d  = op_e'(bus.op);
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == rd_len - CNT_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == wr_end - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (stage_q < last_stage) begin
                        stage_d = stage_q + STAGE_W'(1);
                        state_d = RUN;
                    end else begin
                        stage_d = '0;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from next-state values so every output is a flop.
    // On IDLE->RUN cnt_d is 0 and every latency is nonzero, so the old mode's
    // limits give the right wr_en there too.
    always_comb begin
        rd_en_d = (state_d == RUN);
        busy_d  = (state_d == RUN) || (state_d == DRAIN);
        wr_en_d = busy_d && (cnt_d >= lat) && (cnt_d < wr_end);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= NTT;
            stage_q <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.stage     = stage_q;
    assign bus.cycle_cnt = cnt_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Directed bench for ntt_seq_ctrl: walks every cycle of each operation and
// compares the full output bundle against hand-derived pass geometry.
module tb_ntt_seq_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    ntt_seq_ctrl_if bus ();

    ntt_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {mode[1:0], stage[2:0], cycle_cnt[7:0], rd_en, wr_en, busy, done}
    function automatic logic [31:0] obs();
        return {15'd0, bus.mode, bus.stage, bus.cycle_cnt, bus.rd_en, bus.wr_en, bus.busy,
                bus.done};
    endfunction

    function automatic logic [31:0] pack(input int m, input int s, input int c, input bit rd,
                                         input bit wr, input bit bz, input bit dn);
        logic [1:0] mm;
        logic [2:0] ss;
        logic [7:0] cc;
        mm = m[1:0];
        ss = s[2:0];
        cc = c[7:0];
        return {15'd0, mm, ss, cc, rd, wr, bz, dn};
    endfunction

    // Pulses start (or leaves it held), then checks every cycle of the operation.
    // abort_p >= 0 stops right after checking pass abort_p, cycle abort_c.
    task automatic run_op(input int op, input bit hold, input bit repulse, input int abort_p,
                          input int abort_c);
        int r, l, np;
        case (op)
            2:       begin r = 128; l = 12; np = 1; end
            3:       begin r = 64;  l = 4;  np = 1; end
            default: begin r = 32;  l = 6;  np = 7; end
        endcase
        bus.start = 1'b1;
        bus.op    = op[1:0];
        tick();
        if (!hold) bus.start = 1'b0;
        for (int p = 0; p < np; p++) begin
            for (int c = 0; c < r + l; c++) begin
                check($sformatf("op%0d p%0d c%0d", op, p, c), obs(),
                      pack(op, p, c, c < r, c >= l, 1'b1, 1'b0));
                if (p == abort_p && c == abort_c) return;
                if (repulse && p == 3 && c == 10) begin
                    bus.start = 1'b1;
                    bus.op    = 2'd0;
                end
                if (repulse && p == 3 && c == 11) bus.start = 1'b0;
                tick();
            end
        end
        check($sformatf("op%0d done", op), obs(), pack(op, 0, 0, 0, 0, 0, 1));
        tick();
        check($sformatf("op%0d idle", op), obs(), pack(op, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        rst       = 1'b1;
        #12;
        check("reset", obs(), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_after_reset", obs(), 32'd0);

        run_op(0, 1'b0, 1'b0, -1, 0);   // NTT
        run_op(2, 1'b0, 1'b0, -1, 0);   // MULT
        run_op(3, 1'b0, 1'b0, -1, 0);   // ADDSUB
        run_op(1, 1'b0, 1'b1, -1, 0);   // INVNTT, start re-pulsed mid-stage 3

        // NTT aborted by reset at stage 4, cycle_cnt 20
        run_op(0, 1'b0, 1'b0, 4, 20);
        rst = 1'b1;
        #1;
        check("abort_async", obs(), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_quiet%0d", i), obs(), 32'd0);
        end
        run_op(2, 1'b0, 1'b0, -1, 0);   // accepted after abort

        // start held high: second op accepted on the IDLE cycle after done
        run_op(3, 1'b1, 1'b0, -1, 0);
        run_op(3, 1'b1, 1'b0, -1, 0);
        bus.start = 1'b0;
        tick();
        check("b2b_stays_idle", obs(), pack(3, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
